// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Brief    : Shared state encodings and flag helper for the serial subtractor.
// Revision : 1.0
// ============================================================================
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        SUB_IDLE = 2'b00,
        SUB_BUSY = 2'b01,
        SUB_DONE = 2'b10
    } sub_state_e;

    // Signed overflow of a - b: operands of opposite sign and the result sign differs from a.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_sub_cell.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_cell
// Brief    : Gate-level full adder computing a + ~b + cin (one subtract bit).
// Revision : 1.0
// ============================================================================
module serial_sub_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_b_inv;
    logic w_prop;

    assign w_b_inv = ~b_bit;
    assign w_prop  = a_bit ^ w_b_inv;
    assign sum     = w_prop ^ cin;
    assign cout    = (a_bit & w_b_inv) | (w_prop & cin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial two's-complement subtractor, LSB first, valid/ready I/O.
// Revision : 1.0
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             carryout,
    output logic             overflow
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sub_state_e       r_state;
    sub_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_diff_sh;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_count;
    logic             r_carry;
    logic             r_carryout;
    logic             r_overflow;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_next;

    serial_sub_cell u_cell (
        .a_bit (r_a_sh[0]),
        .b_bit (r_b_sh[0]),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_cout)
    );

    assign w_last      = (r_count == LAST_CNT);
    // Newest sum enters at the MSB; on the last bit this is the complete result.
    assign w_diff_next = {w_sum, r_diff_sh};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SUB_IDLE: if (in_valid)  w_state_nxt = SUB_BUSY;
            SUB_BUSY: if (w_last)    w_state_nxt = SUB_DONE;
            SUB_DONE: if (out_ready) w_state_nxt = SUB_IDLE;
            default:                 w_state_nxt = SUB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SUB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_diff_sh  <= '0;
            r_diff     <= '0;
            r_count    <= '0;
            r_carry    <= 1'b1;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
        end else begin
            case (r_state)
                SUB_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_carry <= 1'b1;
                        r_count <= '0;
                    end
                end
                SUB_BUSY: begin
                    r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_diff_sh <= w_diff_next[WIDTH-1:1];
                    r_carry   <= w_cout;
                    r_count   <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_diff     <= w_diff_next;
                        r_carryout <= w_cout;
                        r_overflow <= sub_overflow(r_a_msb, r_b_msb, w_sum);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == SUB_IDLE);
    assign out_valid = (r_state == SUB_DONE);
    assign diff      = r_diff;
    assign carryout  = r_carryout;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
